// File: rtl/trace_pkg.sv
// Shared types and constants for the a0 trace buffer.
// The default entry type matches the default top-level widths.
package trace_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int TS_WIDTH_DEF   = 16;

  // The drop counter stops at this value instead of wrapping.
  localparam logic [7:0] DROP_MAX = 8'hFF;

  typedef struct packed {
    logic [TS_WIDTH_DEF-1:0]   ts;
    logic [DATA_WIDTH_DEF-1:0] data;
  } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO of trace entries held in plain registers.
// Full and empty are taken from the entry count, so the pointers can wrap freely.
module trace_fifo
  import trace_pkg::*;
#(
  parameter type     entry_t = trace_entry_t,
  parameter int      DEPTH   = 8,
  localparam int     PTR_W   = $clog2(DEPTH),
  localparam int     CNT_W   = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  entry_t           wdata_i,
  output entry_t           rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // Flush overrides both sides. A pop frees a slot for a push on the same edge.
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && (!full_o || do_pop) && !flush_i;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is not reset; a slot is always written before it is read, and an empty read is forced to zero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/a0_trace_buffer.sv
// Captures each change of the CPU a0 value with a cycle timestamp and queues it
// for a consumer that may stall; overflowed captures are counted, never back-pressured.
module a0_trace_buffer
  import trace_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  parameter int  DEPTH      = 8,
  parameter int  TS_WIDTH   = 16,
  localparam int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] a0,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [TS_WIDTH-1:0]   out_ts,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic [7:0]            drop_cnt
);

  typedef struct packed {
    logic [TS_WIDTH-1:0]   ts;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  logic [TS_WIDTH-1:0]   ts_q, ts_d;
  logic [DATA_WIDTH-1:0] last_a0_q, last_a0_d;
  logic                  primed_q, primed_d;
  logic [7:0]            drop_cnt_q, drop_cnt_d;

  logic   capture, pop, push, drop, fifo_empty;
  entry_t wr_entry, rd_entry;

  // The first enabled cycle after reset or flush always captures, even if a0 is unchanged.
  assign capture = en && (!primed_q || (a0 != last_a0_q));
  assign pop     = out_valid && out_ready;
  assign push    = capture && (!full || pop);
  assign drop    = capture && full && !pop && !flush;

  assign wr_entry = '{ts: ts_q, data: a0};

  always_comb begin
    ts_d       = ts_q + 1'b1;
    last_a0_d  = capture ? a0 : last_a0_q;
    primed_d   = flush ? 1'b0 : (capture ? 1'b1 : primed_q);
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != DROP_MAX)) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_q       <= '0;
      last_a0_q  <= '0;
      primed_q   <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      ts_q       <= ts_d;
      last_a0_q  <= last_a0_d;
      primed_q   <= primed_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  trace_fifo #(
    .entry_t (entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .flush_i (flush),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wr_entry),
    .rdata_o (rd_entry),
    .count_o (count),
    .full_o  (full),
    .empty_o (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = rd_entry.data;
  assign out_ts    = rd_entry.ts;
  assign drop_cnt  = drop_cnt_q;

endmodule
